// File: rtl/display_pkg.sv
// Shared constants for the display path: mode encodings and default
// channel geometry / scan rate.
package display_pkg;
  localparam logic MODE_DIRECT   = 1'b0;
  localparam logic MODE_SCAN     = 1'b1;
  localparam int   DISP_W        = 4;
  localparam int   DISP_N        = 8;
  localparam int   DISP_PRESCALE = 16;
endpackage

// File: rtl/rr_next.sv
// Round-robin successor: first enabled channel after idx, searching
// idx+1, idx+2, ... with wrap; idx itself is the last candidate.
module rr_next #(
  parameter  int N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] idx,
  input  logic [N-1:0]     en,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk farthest-first so the nearest enabled candidate wins.
  always_comb begin
    nxt   = idx;
    found = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = SEL_W'((int'(idx) + k) % N);
      if (en[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 channel selector with DIRECT (S picks) and SCAN
// (prescaled rotation over enabled channels) modes.
module scan_mux
  import display_pkg::*;
#(
  parameter  int W        = DISP_W,
  parameter  int N        = DISP_N,
  parameter  int PRESCALE = DISP_PRESCALE,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N*W-1:0]   I,
  input  logic [SEL_W-1:0] S,
  input  logic             Mode,
  input  logic             Hold,
  input  logic [N-1:0]     En_mask,
  output logic [W-1:0]     Y,
  output logic [SEL_W-1:0] Sel_out,
  output logic             Tick
);

  localparam int              PW   = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]   TERM = PW'(PRESCALE - 1);

  logic [N-1:0][W-1:0] gated;
  logic [PW-1:0]       pre_q, nxt_pre;
  logic                mode_q;
  logic [SEL_W-1:0]    nxt_sel, rr_idx;
  logic [W-1:0]        nxt_y;
  logic                nxt_tick, rr_found;

  // Masked channels read as zero before selection.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign gated[k] = En_mask[k] ? I[k*W +: W] : '0;
  end

  // Sel_out doubles as the scan index register.
  rr_next #(.N(N)) u_rr (
    .idx   (Sel_out),
    .en    (En_mask),
    .nxt   (rr_idx),
    .found (rr_found)
  );

  always_comb begin
    nxt_sel  = Sel_out;
    nxt_pre  = '0;
    nxt_tick = 1'b0;
    if (Mode == MODE_DIRECT) begin
      nxt_sel = S;
    end else if (mode_q == MODE_DIRECT) begin
      nxt_sel = (int'(S) < N) ? S : '0;
    end else if (Hold) begin
      nxt_pre = pre_q;
    end else if (pre_q == TERM) begin
      // With no enabled channel the index parks and no tick is raised.
      if (rr_found) begin
        nxt_sel  = rr_idx;
        nxt_tick = 1'b1;
      end
    end else begin
      nxt_pre = pre_q + 1'b1;
    end
  end

  always_comb begin
    nxt_y = '0;
    if (int'(nxt_sel) < N) nxt_y = gated[nxt_sel];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Y       <= '0;
      Sel_out <= '0;
      Tick    <= 1'b0;
      pre_q   <= '0;
      mode_q  <= MODE_DIRECT;
    end else begin
      Y       <= nxt_y;
      Sel_out <= nxt_sel;
      Tick    <= nxt_tick;
      pre_q   <= nxt_pre;
      mode_q  <= Mode;
    end
  end

endmodule
